// File: rtl/veririsc_pkg.sv
// Shared VeriRISC encodings: opcodes, sequencer phases and the controller strobe bundle.
package veririsc_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic wr;
        logic data_e;
        logic halt;
        logic instr_done;
    } ctrl_t;

    // Opcodes whose result comes from the ALU and therefore read an operand from memory.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/veririsc_ctrl_decode.sv
// Phase/opcode decode into datapath strobes and levels.
// Latency: purely combinational, zero cycles.
// Backpressure: en low suppresses every strobe; levels stay driven.
module veririsc_ctrl_decode
    import veririsc_pkg::*;
(
    input  logic [2:0] phase,
    input  logic       halted,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       en,
    output ctrl_t      ctrl
);

    logic  alu_op;
    ctrl_t raw;

    assign alu_op = is_aluop(opcode);

    always_comb begin
        raw = '0;
        if (halted) begin
            raw.halt = 1'b1;
        end else begin
            case (phase)
                PH_INST_ADDR: begin
                    raw.sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    raw.sel = 1'b1;
                    raw.rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    raw.sel   = 1'b1;
                    raw.rd    = 1'b1;
                    raw.ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    raw.inc_pc = 1'b1;
                    raw.halt   = (opcode == OP_HLT);
                end
                PH_OP_FETCH: begin
                    raw.rd = alu_op;
                end
                PH_ALU_OP: begin
                    raw.rd     = alu_op;
                    raw.inc_pc = (opcode == OP_SKZ) && zero;
                    raw.ld_pc  = (opcode == OP_JMP);
                    raw.data_e = (opcode == OP_STO);
                end
                PH_STORE: begin
                    raw.rd         = alu_op;
                    raw.ld_ac      = alu_op;
                    raw.inc_pc     = (opcode == OP_JMP);
                    raw.ld_pc      = (opcode == OP_JMP);
                    raw.data_e     = (opcode == OP_STO);
                    raw.wr         = (opcode == OP_STO);
                    raw.instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Gating strobes with en keeps a stalled phase from repeating its side effect.
    always_comb begin
        ctrl            = raw;
        ctrl.ld_ir      = raw.ld_ir      & en;
        ctrl.inc_pc     = raw.inc_pc     & en;
        ctrl.ld_pc      = raw.ld_pc      & en;
        ctrl.ld_ac      = raw.ld_ac      & en;
        ctrl.wr         = raw.wr         & en;
        ctrl.instr_done = raw.instr_done & en;
    end

endmodule

// File: rtl/veririsc_controller.sv
// VeriRISC eight-phase instruction sequencer: phase counter plus sticky halt flag.
// Latency: outputs combinational from registered phase and current opcode/zero.
// Backpressure: en=0 holds the phase and masks strobes; halted ignores en until reset.
module veririsc_controller
    import veririsc_pkg::*;
#(
    parameter int OPCODE_WIDTH = 3,
    parameter int PHASE_WIDTH  = 3
) (
    input  logic                    clk,
    input  logic                    rst_,
    input  logic                    en,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    output logic                    sel,
    output logic                    rd,
    output logic                    ld_ir,
    output logic                    inc_pc,
    output logic                    ld_pc,
    output logic                    ld_ac,
    output logic                    wr,
    output logic                    data_e,
    output logic                    halt,
    output logic [PHASE_WIDTH-1:0]  phase,
    output logic                    instr_done
);

    logic [PHASE_WIDTH-1:0] phase_q;
    logic                   halted_q;
    ctrl_t                  ctrl;

    // Halting leaves phase_q at OP_ADDR, which is what the debug output shows while halted.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else if (!halted_q && en) begin
            if (phase_q == PH_OP_ADDR && opcode == OP_HLT) begin
                halted_q <= 1'b1;
            end else begin
                phase_q <= phase_q + 1'b1;
            end
        end
    end

    veririsc_ctrl_decode u_decode (
        .phase  (phase_q),
        .halted (halted_q),
        .opcode (opcode),
        .zero   (zero),
        .en     (en),
        .ctrl   (ctrl)
    );

    // Reset forces everything low so an abandoned instruction cannot fire a strobe.
    assign {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, instr_done} =
        rst_ ? ctrl : '0;
    assign phase = rst_ ? phase_q : '0;

endmodule
